// File: rtl/trunk_line_sequencer_pkg.sv
// Shared definitions for the trunk line sequencer: request modes, FSM states, defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trunk_pkg;

  // Request mode encodings
  localparam logic [1:0] MODE_WORD  = 2'b00;
  localparam logic [1:0] MODE_BYTE  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PRE    = 2'd2
  } state_t;

  // Default geometry of the trunk
  localparam int DEF_NUM_LINES  = 32;
  localparam int DEF_LANE_WIDTH = 8;

endpackage

// File: rtl/trunk_line_sequencer_if.sv
// Request/response and line-enable bundle between array controller and sequencer.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready handshake; line enables are not backpressured.
interface trunk_line_sequencer_if #(
  parameter int NUM_LINES = trunk_pkg::DEF_NUM_LINES,
  parameter int SEL_W     = $clog2(NUM_LINES)
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_mode;
  logic [SEL_W-1:0]     req_sel;
  logic [SEL_W-1:0]     req_len;
  logic                 trunk_enable;
  logic [NUM_LINES-1:0] line_en;
  logic                 busy;
  logic                 done;
  logic                 err;

  // Array controller side
  modport master (
    output req_valid, req_mode, req_sel, req_len, trunk_enable,
    input  req_ready, line_en, busy, done, err
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_mode, req_sel, req_len, trunk_enable,
    output req_ready, line_en, busy, done, err
  );
endinterface

// File: rtl/trunk_line_sequencer_pattern.sv
// Line-enable pattern for a (mode, sel) pair: one-hot for word/burst, lane-replicated for byte.
// Latency: combinational; the parent registers the result.
// Backpressure: none.
module trunk_line_pattern
  import trunk_pkg::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int SEL_W      = $clog2(NUM_LINES)
) (
  input  logic [1:0]           mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [NUM_LINES-1:0] pattern
);

  localparam int NUM_LANES = NUM_LINES / LANE_WIDTH;

  // LANE_WIDTH divides a power-of-two NUM_LINES, so it is itself a power of two
  // and the in-lane offset is just the low bits of sel.
  logic [SEL_W-1:0] lane_off;
  assign lane_off = sel & SEL_W'(LANE_WIDTH - 1);

  // Build the enable pattern; reserved mode yields no lines at all
  always_comb begin
    pattern = '0;
    if (mode == MODE_BYTE) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        pattern[SEL_W'(k * LANE_WIDTH) | lane_off] = 1'b1;
      end
    end else if (mode == MODE_WORD || mode == MODE_BURST) begin
      pattern[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/trunk_line_sequencer.sv
// Trunk line sequencer: accepts activation requests and drives timed line enables with precharge gaps.
// Latency: line_en registered at the accept edge; done one cycle after the last precharge cycle.
// Backpressure: req_ready only in IDLE (including the done cycle, allowing back-to-back requests).
module trunk_line_sequencer
  import trunk_pkg::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int ACT_CYCLES = 2,
  parameter int PRE_CYCLES = 1,
  parameter int SEL_W      = $clog2(NUM_LINES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  trunk_line_sequencer_if.slave   bus
);

  localparam int CNT_MAX = (ACT_CYCLES > PRE_CYCLES) ? ACT_CYCLES : PRE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(ACT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     rem_q, rem_d;
  logic [1:0]           mode_q, mode_d;
  logic                 abort_q, abort_d;
  logic [NUM_LINES-1:0] line_en_q, line_en_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [1:0]           pat_mode;
  logic [SEL_W-1:0]     pat_sel;
  logic [NUM_LINES-1:0] pat;
  logic                 illegal;

  trunk_line_pattern #(
    .NUM_LINES  (NUM_LINES),
    .LANE_WIDTH (LANE_WIDTH),
    .SEL_W      (SEL_W)
  ) u_pattern (
    .mode    (pat_mode),
    .sel     (pat_sel),
    .pattern (pat)
  );

  // Byte mode only addresses lines inside the first lane
  assign illegal = (bus.req_mode == MODE_RSVD)
                 || (bus.req_mode == MODE_BYTE && (bus.req_sel & ~SEL_W'(LANE_WIDTH - 1)) != '0)
                 || !bus.trunk_enable;

  // Next-state, counters and registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    rem_d     = rem_q;
    mode_d    = mode_q;
    abort_d   = abort_q;
    line_en_d = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    pat_mode  = mode_q;
    pat_sel   = sel_q + SEL_ONE;

    case (state_q)
      ST_IDLE: begin
        pat_mode = bus.req_mode;
        pat_sel  = bus.req_sel;
        if (bus.req_valid) begin
          mode_d  = bus.req_mode;
          sel_d   = bus.req_sel;
          rem_d   = (bus.req_mode == MODE_BURST) ? bus.req_len : '0;
          abort_d = 1'b0;
          if (illegal) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d   = ST_ACTIVE;
            cnt_d     = ACT_LOAD;
            line_en_d = pat;
          end
        end
      end

      ST_ACTIVE: begin
        line_en_d = line_en_q;
        if (!bus.trunk_enable) begin
          state_d   = ST_PRE;
          cnt_d     = PRE_LOAD;
          abort_d   = 1'b1;
          line_en_d = '0;
        end else if (cnt_q == '0) begin
          state_d   = ST_PRE;
          cnt_d     = PRE_LOAD;
          line_en_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_PRE: begin
        // A trunk drop anywhere in precharge cancels the rest of the burst
        abort_d = abort_q || !bus.trunk_enable;
        if (cnt_q == '0) begin
          if (mode_q == MODE_BURST && rem_q != '0 && !abort_d) begin
            state_d   = ST_ACTIVE;
            cnt_d     = ACT_LOAD;
            sel_d     = sel_q + SEL_ONE;
            rem_d     = rem_q - SEL_ONE;
            line_en_d = pat;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = abort_d;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears line enables asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      rem_q     <= '0;
      mode_q    <= MODE_WORD;
      abort_q   <= 1'b0;
      line_en_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      rem_q     <= rem_d;
      mode_q    <= mode_d;
      abort_q   <= abort_d;
      line_en_q <= line_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.line_en   = line_en_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_trunk_line_sequencer.sv
// Directed bench for trunk_line_sequencer at default parameters (32 lines, 8-line lanes, 2 act, 1 pre).
// Inputs change and outputs are sampled on the falling clock edge.
// Every expected value is a hand-computed constant per scenario.
module tb_trunk_line_sequencer;
  import trunk_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  trunk_line_sequencer_if #(.NUM_LINES(32), .SEL_W(5)) bus ();

  trunk_line_sequencer #(
    .NUM_LINES  (32),
    .LANE_WIDTH (8),
    .ACT_CYCLES (2),
    .PRE_CYCLES (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for a single rising edge; returns on the following falling edge
  task automatic issue(input logic [1:0] mode, input logic [4:0] sel, input logic [4:0] len);
    bus.req_valid = 1'b1;
    bus.req_mode  = mode;
    bus.req_sel   = sel;
    bus.req_len   = len;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    // Reset state
    n_cmp++;
    if (bus.line_en !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: line_en=%h busy=%b done=%b err=%b, want 0/0/0/0", bus.line_en, bus.busy, bus.done, bus.err);
    end
    issue(MODE_WORD, 5'd5, 5'd0);
    n_cmp++;
    if (bus.line_en !== 32'h0000_0020) begin
      n_bad++;
      $display("FAIL reset_pre_active: line_en=%h want 00000020", bus.line_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.line_en !== 32'h0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async_clear: line_en=%h busy=%b, want 0/0", bus.line_en, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.line_en !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_release[%0d]: ready=%b busy=%b done=%b line_en=%h, want 1/0/0/0", i, bus.req_ready, bus.busy, bus.done, bus.line_en);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_word();
    logic [31:0] exp_le [0:4];
    logic        exp_dn [0:4];
    logic        exp_bz [0:4];
    exp_le = '{32'h20, 32'h20, 32'h0, 32'h0, 32'h0};
    exp_dn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_bz = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    issue(MODE_WORD, 5'd5, 5'd0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.line_en !== exp_le[i] || bus.done !== exp_dn[i] || bus.busy !== exp_bz[i] || bus.err !== 1'b0) begin
        n_bad++;
        $display("FAIL word[%0d]: line_en=%h done=%b busy=%b err=%b, want %h/%b/%b/0", i, bus.line_en, bus.done, bus.busy, bus.err, exp_le[i], exp_dn[i], exp_bz[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_byte();
    logic [31:0] exp_le [0:3];
    logic        exp_dn [0:3];
    exp_le = '{32'h0808_0808, 32'h0808_0808, 32'h0, 32'h0};
    exp_dn = '{1'b0, 1'b0, 1'b0, 1'b1};
    issue(MODE_BYTE, 5'd3, 5'd0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.line_en !== exp_le[i] || bus.done !== exp_dn[i] || bus.err !== 1'b0) begin
        n_bad++;
        $display("FAIL byte[%0d]: line_en=%h done=%b err=%b, want %h/%b/0", i, bus.line_en, bus.done, bus.err, exp_le[i], exp_dn[i]);
      end
      @(negedge clk);
    end
    // Out-of-lane select is rejected without activation
    issue(MODE_BYTE, 5'd9, 5'd0);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.line_en !== 32'h0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL byte_illegal: done=%b err=%b line_en=%h busy=%b, want 1/1/0/0", bus.done, bus.err, bus.line_en, bus.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.err !== 1'b0 || bus.line_en !== 32'h0) begin
      n_bad++;
      $display("FAIL byte_illegal_after: done=%b err=%b line_en=%h, want 0/0/0", bus.done, bus.err, bus.line_en);
    end
    @(negedge clk);
  endtask

  task automatic test_burst();
    logic [31:0] acts [0:3];
    logic [31:0] exp_le;
    logic        exp_dn;
    acts = '{32'h4000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0002};
    issue(MODE_BURST, 5'd30, 5'd3);
    for (int i = 0; i < 14; i++) begin
      exp_le = (i < 12 && (i % 3) < 2) ? acts[i / 3] : 32'h0;
      exp_dn = (i == 12);
      n_cmp++;
      if (bus.line_en !== exp_le || bus.done !== exp_dn || bus.err !== 1'b0) begin
        n_bad++;
        $display("FAIL burst[%0d]: line_en=%h done=%b err=%b, want %h/%b/0", i, bus.line_en, bus.done, bus.err, exp_le, exp_dn);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    logic [31:0] exp_le [0:9];
    logic        exp_dn [0:9];
    logic        exp_bz [0:9];
    exp_le = '{32'h1, 32'h1, 32'h0, 32'h2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_dn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_bz = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    issue(MODE_BURST, 5'd0, 5'd7);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (bus.line_en !== exp_le[i] || bus.done !== exp_dn[i] || bus.err !== exp_dn[i] || bus.busy !== exp_bz[i]) begin
        n_bad++;
        $display("FAIL abort[%0d]: line_en=%h done=%b err=%b busy=%b, want %h/%b/%b/%b", i, bus.line_en, bus.done, bus.err, bus.busy, exp_le[i], exp_dn[i], exp_dn[i], exp_bz[i]);
      end
      if (i == 3) bus.trunk_enable = 1'b0;
      if (i == 5) bus.trunk_enable = 1'b1;
      @(negedge clk);
    end
    // Trunk disabled at acceptance is an illegal request
    bus.trunk_enable = 1'b0;
    issue(MODE_WORD, 5'd4, 5'd0);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.line_en !== 32'h0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL trunk_off_accept: done=%b err=%b line_en=%h busy=%b, want 1/1/0/0", bus.done, bus.err, bus.line_en, bus.busy);
    end
    bus.trunk_enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_le [0:7];
    logic        exp_dn [0:7];
    logic        exp_rd [0:7];
    exp_le = '{32'h2, 32'h2, 32'h0, 32'h0, 32'h4, 32'h4, 32'h0, 32'h0};
    exp_dn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_rd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.req_valid = 1'b1;
    bus.req_mode  = MODE_WORD;
    bus.req_sel   = 5'd1;
    bus.req_len   = 5'd0;
    @(negedge clk);
    // Second request queued behind the first; valid stays high
    bus.req_sel = 5'd2;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bus.line_en !== exp_le[i] || bus.done !== exp_dn[i] || bus.req_ready !== exp_rd[i] || bus.err !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b[%0d]: line_en=%h done=%b ready=%b err=%b, want %h/%b/%b/0", i, bus.line_en, bus.done, bus.req_ready, bus.err, exp_le[i], exp_dn[i], exp_rd[i]);
      end
      if (i == 4) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    // Reserved mode: error with no line activity
    issue(MODE_RSVD, 5'd0, 5'd0);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.line_en !== 32'h0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rsvd: done=%b err=%b line_en=%h busy=%b, want 1/1/0/0", bus.done, bus.err, bus.line_en, bus.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.line_en !== 32'h0) begin
      n_bad++;
      $display("FAIL rsvd_after: done=%b line_en=%h, want 0/0", bus.done, bus.line_en);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_mode     = MODE_WORD;
    bus.req_sel      = '0;
    bus.req_len      = '0;
    bus.trunk_enable = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_word();
    test_byte();
    test_burst();
    test_abort();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trunk_line_sequencer.md
Name: trunk_line_sequencer

Overview:
- Parametrised, registered successor to the trunk word/byte line decoder.
- Accepts a line-activation request over a valid/ready handshake and drives one-hot (word) or lane-replicated (byte) line enables for a programmable activate window, followed by a precharge gap.
- Adds a burst mode that auto-increments the line select, plus abort on trunk disable.
- Sits between the array controller and the trunk line drivers.

Parameters:
- NUM_LINES, 32, number of line enables driven; power of two, >= LANE_WIDTH.
- LANE_WIDTH, 8, lines per byte lane; NUM_LINES must be a multiple of it.
- ACT_CYCLES, 2, cycles line_en is held per activation; >= 1.
- PRE_CYCLES, 1, cycles of all-zero line_en between activations; >= 1.
- SEL_W, $clog2(NUM_LINES), select and length width (derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_mode  in  2  00 word, 01 byte, 10 word-burst, 11 reserved.
- req_sel  in  SEL_W  start line index.
- req_len  in  SEL_W  burst activations minus 1; ignored unless mode 10.
- trunk_enable  in  1  trunk permitted; low aborts an operation in progress.
- line_en  out  NUM_LINES  registered line enables.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse at completion, including error and abort.
- err  out  1  one-cycle pulse, coincident with done, on illegal request or abort.

Behaviour:
- Reset (async, rst_n low): state IDLE, line_en=0, done=0, err=0, busy=0, req_ready=1 after release. Internal sel, remaining-count and cycle counter are cleared.
- Reset mid-operation: line_en clears immediately and asynchronously; no done pulse is produced.
- Handshake: a request is accepted at the rising edge where req_valid && req_ready; inputs are captured at that edge. req_ready=0 in ACTIVE and PRECHARGE.
- FSM states: IDLE, ACTIVE, PRECHARGE.
- IDLE -> ACTIVE on an accepted legal request with trunk_enable=1.
  - An accepted request is illegal if mode=11, or mode=01 with req_sel >= LANE_WIDTH, or trunk_enable=0 at acceptance.
  - Illegal request: no activation, FSM stays in IDLE, done=1 and err=1 on the next cycle.
- ACTIVE lasts ACT_CYCLES cycles; line_en is stable throughout.
  - Word/burst mode: line_en = one-hot(sel).
  - Byte mode: bit (sel + k*LANE_WIDTH) is set for every lane k.
  - Latency: request accepted at edge N; line_en is valid from edge N+1 through edge N+ACT_CYCLES.
- ACTIVE -> PRECHARGE after ACT_CYCLES cycles; line_en=0 for PRE_CYCLES cycles.
- PRECHARGE exit:
  - If mode=10 and remaining > 0: sel = (sel+1) mod NUM_LINES (wraps at NUM_LINES-1 to 0), remaining decrements, return to ACTIVE.
  - Otherwise go to IDLE with done=1 for one cycle. req_ready is also 1 in that cycle, so back-to-back requests are allowed.
- Abort: trunk_enable sampled low in ACTIVE means line_en=0 from the next edge and the FSM goes to PRECHARGE. The full PRE_CYCLES is still honoured, then IDLE with done=1, err=1; any remaining burst is discarded.
- trunk_enable low during PRECHARGE: the burst is cancelled and the FSM exits to IDLE with done=1, err=1 after precharge completes.
- Burst count: total activations = req_len+1. req_len = NUM_LINES-1 sweeps every line exactly once.
- Cycle counter width: clog2(max(ACT_CYCLES, PRE_CYCLES))+1. It reloads on every state entry.
- Invariant: at most one line is active in word/burst mode; line_en=0 in IDLE and PRECHARGE.

Decomposition:
- Shared package trunk_pkg holds:
  - mode encodings MODE_WORD=2'b00, MODE_BYTE=2'b01, MODE_BURST=2'b10, MODE_RSVD=2'b11;
  - FSM state encoding;
  - default NUM_LINES and LANE_WIDTH constants.
- One sub-module, trunk_line_pattern: a combinational function of (mode, sel) producing the NUM_LINES-bit pattern, registered in the parent. All FSM, counters and handshake stay in the parent.

Test Plan:
- Reset then idle: rst_n low mid-ACTIVE -> line_en=0 immediately; after release req_ready=1, busy=0, no done.
- Word mode, defaults, sel=5 -> line_en=0x00000020 for exactly 2 cycles starting the cycle after accept, then 0 for 1 cycle, then done=1, err=0, busy=0.
- Byte mode, sel=3 -> line_en=0x08080808 for 2 cycles. Byte mode, sel=9 -> no activation, done=1, err=1 one cycle after accept.
- Burst mode, sel=30, len=3 -> activations 0x40000000, 0x80000000, 0x00000001, 0x00000002, each 2 cycles separated by 1-cycle zero gaps; single done pulse at end.
- Abort: burst sel=0, len=7, drop trunk_enable during the second activation -> line_en=0 next cycle, 1 precharge cycle, done=1, err=1, no further activations.
- Handshake: hold req_valid high with two queued requests -> second request accepted in the same cycle done pulses; mode=11 yields err=1 with no line_en activity.
